// File: rtl/path_extract_if.sv
// Pose stream handshake from path_extract to the trajectory stage.
interface path_extract_if;
    logic       pose_valid;
    logic [7:0] pose_data;
    logic       pose_last;
    logic       pose_ready;

    modport master (
        output pose_valid,
        output pose_data,
        output pose_last,
        input  pose_ready
    );

    modport slave (
        input  pose_valid,
        input  pose_data,
        input  pose_last,
        output pose_ready
    );
endinterface

// File: rtl/path_extract.sv
// Walks the selected-edge list backwards and streams the ordered pose chain.
// Optional revisit detection is enabled with PATH_LOOP_CHECK_EN.
module path_extract #(
    parameter int POSE_NUM = 66,
    parameter int MAX_EDGE = 10,
    parameter int RAM_LAT  = 1
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  start,
    input  logic [MAX_EDGE*11-1:0] selectEdge,
    input  logic [3:0]            edgeCount,
    input  logic [7:0]            startPose,
    input  logic [7:0]            endPose,
    output logic [10:0]           ramAddress,
    input  logic [15:0]           RAMData,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    path_extract_if.master        pose
);

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        RD_REQ,
        RD_WAIT,
        RESOLVE,
        DONE,
        ERR
    } state_t;

    state_t               state_q;
    logic [MAX_EDGE*11-1:0] sel_q;
    logic [7:0]           end_q;
    logic [7:0]           cur_q;
    logic [3:0]           idx_q;
    logic [3:0]           wcnt_q;
    logic [10:0]          addr_q;
    logic                 valid_q;
    logic [7:0]           data_q;
    logic                 last_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic [6:0]  off_d;
    logic [10:0] slot_d;
    logic [7:0]  first_d;
    logic [7:0]  second_d;
    logic [7:0]  next_d;
    logic        bad_d;
    logic        reject_d;
    logic        loop_hit_d;

`ifdef PATH_LOOP_CHECK_EN
    logic [POSE_NUM-1:0] vis_q;
    logic [POSE_NUM-1:0] next_oh_d;
    logic [POSE_NUM-1:0] start_oh_d;

    assign next_oh_d  = {{(POSE_NUM-1){1'b0}}, 1'b1} << next_d;
    assign start_oh_d = {{(POSE_NUM-1){1'b0}}, 1'b1} << startPose;
    assign loop_hit_d = |(vis_q & next_oh_d);
`else
    assign loop_hit_d = 1'b0;
`endif

    assign off_d    = 7'(idx_q) * 7'd11;
    assign slot_d   = sel_q[off_d +: 11];
    assign first_d  = RAMData[15:8];
    assign second_d = RAMData[7:0];

    always_comb begin
        next_d = first_d;
        if (first_d == cur_q)
            next_d = second_d;
        bad_d = 1'b0;
        if (first_d != cur_q && second_d != cur_q)
            bad_d = 1'b1;
        if (int'(next_d) >= POSE_NUM || first_d == second_d)
            bad_d = 1'b1;
        if (idx_q == 4'd0 && next_d != end_q)
            bad_d = 1'b1;
        if (loop_hit_d)
            bad_d = 1'b1;
    end

    // Start is refused outright when the request cannot describe a path.
    assign reject_d = (edgeCount == 4'd0)
                    || (int'(edgeCount) > MAX_EDGE)
                    || (int'(startPose) >= POSE_NUM)
                    || (int'(endPose) >= POSE_NUM);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            end_q   <= '0;
            cur_q   <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PATH_LOOP_CHECK_EN
            vis_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q  <= selectEdge;
                        end_q  <= endPose;
                        busy_q <= 1'b1;
                        if (reject_d) begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end else begin
                            err_q   <= 1'b0;
                            cur_q   <= startPose;
                            idx_q   <= edgeCount - 4'd1;
                            data_q  <= startPose;
                            last_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= EMIT;
`ifdef PATH_LOOP_CHECK_EN
                            vis_q   <= start_oh_d;
`endif
                        end
                    end
                end
                EMIT: begin
                    if (pose.pose_ready) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    addr_q  <= slot_d;
                    wcnt_q  <= 4'(RAM_LAT - 1);
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wcnt_q == 4'd0)
                        state_q <= RESOLVE;
                    else
                        wcnt_q <= wcnt_q - 4'd1;
                end
                RESOLVE: begin
                    if (bad_d) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cur_q   <= next_d;
                        data_q  <= next_d;
                        valid_q <= 1'b1;
                        last_q  <= (idx_q == 4'd0);
                        if (idx_q != 4'd0)
                            idx_q <= idx_q - 4'd1;
                        state_q <= EMIT;
`ifdef PATH_LOOP_CHECK_EN
                        vis_q   <= vis_q | next_oh_d;
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ERR: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ramAddress      = addr_q;
    assign pose.pose_valid = valid_q;
    assign pose.pose_data  = data_q;
    assign pose.pose_last  = last_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = err_q;

endmodule

// File: tb/tb_path_extract.sv
// Directed bench for path_extract: pose chains, stalls, errors and reset.
module tb_path_extract;

    logic         CLK;
    logic         RST_n;
    logic         start;
    logic [109:0] selectEdge;
    logic [3:0]   edgeCount;
    logic [7:0]   startPose;
    logic [7:0]   endPose;
    logic [10:0]  ramAddress;
    logic [15:0]  RAMData;
    logic         busy;
    logic         done;
    logic         error;

    path_extract_if bus ();

    path_extract dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .start      (start),
        .selectEdge (selectEdge),
        .edgeCount  (edgeCount),
        .startPose  (startPose),
        .endPose    (endPose),
        .ramAddress (ramAddress),
        .RAMData    (RAMData),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pose       (bus)
    );

    logic [15:0] mem [0:2047];
    int n_chk;
    int n_pass;
    int got_q[$];
    int n_last;
    int last_pose;
    int n_valid;
    int n_done;
    int n_viol;
    bit hold;
    logic [7:0] held;
    bit bp;
    int phase;
    int cyc;
    logic [3:0] pat;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) RAMData <= mem[ramAddress];

    always @(negedge CLK) begin
        pat = 4'b1001;
        bus.pose_ready = bp ? pat[3 - phase] : 1'b1;
        phase = (phase + 1) % 4;
    end

    always @(posedge CLK) begin
        if (bus.pose_valid && bus.pose_ready) begin
            got_q.push_back(int'(bus.pose_data));
            if (bus.pose_last) begin
                n_last++;
                last_pose = int'(bus.pose_data);
            end
        end
        if (bus.pose_valid) n_valid++;
        if (done) n_done++;
        if (hold && bus.pose_valid && bus.pose_data != held) n_viol++;
        hold = bus.pose_valid && !bus.pose_ready;
        held = bus.pose_data;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic logic [109:0] mksel(input logic [10:0] s2,
                                          input logic [10:0] s1,
                                          input logic [10:0] s0);
        return {77'd0, s2, s1, s0};
    endfunction

    task automatic clr();
        got_q.delete();
        n_last = 0;
        last_pose = -1;
        n_valid = 0;
        n_done = 0;
        n_viol = 0;
    endtask

    task automatic poses(input string tag, input int exp[$]);
        chk({tag, "_n"}, got_q.size(), exp.size());
        foreach (exp[i])
            chk($sformatf("%s_p%0d", tag, i),
                (i < got_q.size()) ? got_q[i] : -1, exp[i]);
    endtask

    task automatic run(input logic [7:0] sp, input logic [7:0] ep,
                       input logic [3:0] cnt, input logic [109:0] sel,
                       input bit restart, output bit first_v);
        clr();
        @(negedge CLK);
        startPose = sp;
        endPose = ep;
        edgeCount = cnt;
        selectEdge = sel;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        first_v = bus.pose_valid;
        cyc = 0;
        while (busy && cyc < 300) begin
            cyc++;
            if (restart && cyc == 3) begin
                selectEdge = '1;
                startPose = 8'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
        end
        start = 1'b0;
        if (busy) chk("timeout", 32'd1, 32'd0);
    endtask

    bit fv;
    logic [109:0] nom;

    initial begin
        n_chk = 0;
        n_pass = 0;
        bp = 1'b0;
        phase = 0;
        hold = 1'b0;
        RST_n = 1'b0;
        start = 1'b0;
        selectEdge = '0;
        edgeCount = '0;
        startPose = '0;
        endPose = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        mem[100] = {8'd3, 8'd5};
        mem[40]  = {8'd7, 8'd5};
        mem[2]   = {8'd9, 8'd7};
        mem[50]  = {8'd3, 8'd5};
        mem[51]  = {8'd5, 8'd3};
        mem[52]  = {8'd3, 8'd9};
        nom = mksel(11'd100, 11'd40, 11'd2);
        clr();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.pose_valid, 0);
        chk("rst_addr", ramAddress, 0);
        chk("rst_data", bus.pose_data, 0);
        chk("rst_last", bus.pose_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        @(negedge CLK);
        RST_n = 1'b1;

        // nominal, ready held high
        run(8'd3, 8'd9, 4'd3, nom, 1'b0, fv);
        chk("nom_first", fv, 1);
        poses("nom", '{3, 5, 7, 9});
        chk("nom_nlast", n_last, 1);
        chk("nom_lastpose", last_pose, 9);
        chk("nom_done", n_done, 1);
        chk("nom_err", error, 0);
        chk("nom_cycles", cyc, 14);

        // backpressure plus an ignored restart mid-walk
        bp = 1'b1;
        run(8'd3, 8'd9, 4'd3, nom, 1'b1, fv);
        bp = 1'b0;
        poses("bp", '{3, 5, 7, 9});
        chk("bp_stable", n_viol, 0);
        chk("bp_done", n_done, 1);
        chk("bp_err", error, 0);

        // broken chain on slot 1
        mem[40] = {8'd20, 8'd21};
        run(8'd3, 8'd9, 4'd3, nom, 1'b0, fv);
        mem[40] = {8'd7, 8'd5};
        poses("brk", '{3, 5});
        chk("brk_err", error, 1);
        chk("brk_done", n_done, 0);
        chk("brk_last", n_last, 0);
        chk("brk_busy", busy, 0);

        // bad counts and out-of-range pose
        run(8'd3, 8'd9, 4'd0, nom, 1'b0, fv);
        chk("cnt0_err", error, 1);
        chk("cnt0_lat", cyc <= 2, 1);
        chk("cnt0_valid", n_valid, 0);
        chk("cnt0_busy", busy, 0);
        run(8'd3, 8'd9, 4'd11, nom, 1'b0, fv);
        chk("cnt11_err", error, 1);
        chk("cnt11_lat", cyc <= 2, 1);
        chk("cnt11_valid", n_valid, 0);
        run(8'd66, 8'd9, 4'd3, nom, 1'b0, fv);
        chk("sp66_err", error, 1);
        chk("sp66_valid", n_valid, 0);
        run(8'd3, 8'd9, 4'd3, nom, 1'b0, fv);
        chk("clr_err", error, 0);

        // reset while waiting on the second edge read
        clr();
        @(negedge CLK);
        startPose = 8'd3;
        endPose = 8'd9;
        edgeCount = 4'd3;
        selectEdge = nom;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cyc = 0;
        while (ramAddress != 11'd40 && cyc < 50) begin
            cyc++;
            @(negedge CLK);
        end
        chk("mid_reach", ramAddress, 40);
        #2 RST_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_addr", ramAddress, 0);
        chk("mid_valid", bus.pose_valid, 0);
        chk("mid_data", bus.pose_data, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_idle", busy, 0);
        run(8'd3, 8'd9, 4'd3, nom, 1'b0, fv);
        poses("post", '{3, 5, 7, 9});
        chk("post_done", n_done, 1);

        // path that revisits pose 3
        run(8'd3, 8'd9, 4'd3, mksel(11'd50, 11'd51, 11'd52), 1'b0, fv);
`ifdef PATH_LOOP_CHECK_EN
        poses("loop", '{3, 5});
        chk("loop_err", error, 1);
        chk("loop_done", n_done, 0);
`else
        poses("loop", '{3, 5, 3, 9});
        chk("loop_err", error, 0);
        chk("loop_done", n_done, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
